// File: rtl/scu_clk_div6_if.sv
// Configuration port of the six-channel SCU clock divider: valid/ready request
// carrying a channel index, an enable and a divide ratio.
interface scu_clk_div6_if;
    logic       cfg_valid_i;
    logic       cfg_ready_o;
    logic [2:0] cfg_sel_i;
    logic       cfg_en_i;
    logic [7:0] cfg_div_i;

    // Requester side: drives the request, observes ready
    modport master (
        output cfg_valid_i,
        output cfg_sel_i,
        output cfg_en_i,
        output cfg_div_i,
        input  cfg_ready_o
    );

    // Divider side: consumes the request, returns ready
    modport slave (
        input  cfg_valid_i,
        input  cfg_sel_i,
        input  cfg_en_i,
        input  cfg_div_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/scu_clk_div6.sv
// Six-channel programmable clock divider for the SCU.
// Each channel divides clk by a run-time programmable ratio (2..255).
// Ratio/enable updates are held pending and applied only at a period boundary
// (end of low phase), or on the next cycle if the channel is disabled.
// Optional feature macro: SCU_CLK_DIV_ODD_EN enables odd divide ratios; when
// undefined, bit 0 of every ratio is forced to 0 so all outputs are 50% duty.
module scu_clk_div6 #(
    parameter int unsigned DIV_RST = 2,
    parameter logic [5:0]  EN_RST  = 6'b111111
) (
    input  logic                 clk,
    input  logic                 rst,
    scu_clk_div6_if.slave        cfg,
    output logic [5:0]           clk_o,
    output logic [5:0]           busy_o
);

    localparam int unsigned NCH = 6;
    localparam int unsigned DW  = 8;

    // Normalise a requested ratio: optional even-forcing, then clamp 0/1 to 2
    function automatic logic [DW-1:0] norm_div(input logic [DW-1:0] raw);
        logic [DW-1:0] v;
`ifdef SCU_CLK_DIV_ODD_EN
        v = raw;
`else
        v = {raw[DW-1:1], 1'b0};
`endif
        if (v < DW'(2)) begin
            v = DW'(2);
        end
        return v;
    endfunction

    localparam logic [DW-1:0] DIV_RST_N = norm_div(DW'(DIV_RST));

    logic [DW-1:0] div_q  [NCH];
    logic [DW-1:0] cnt_q  [NCH];
    logic [DW-1:0] pdiv_q [NCH];
    logic [NCH-1:0] en_q;
    logic [NCH-1:0] pen_q;
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] clk_q;

    logic [NCH-1:0] wrap;
    logic [NCH-1:0] accept;
    logic [NCH-1:0] apply;
    logic           ready;

    // Channel decode, handshake ready, period-end and apply detection
    always_comb begin
        ready  = 1'b1;
        accept = '0;
        apply  = '0;
        wrap   = '0;
        for (int n = 0; n < NCH; n++) begin
            if (cfg.cfg_sel_i == 3'(n)) begin
                ready     = ~pend_q[n];
                accept[n] = cfg.cfg_valid_i & ~pend_q[n];
            end
            wrap[n]  = (cnt_q[n] == (div_q[n] - DW'(1)));
            apply[n] = pend_q[n] & (~en_q[n] | wrap[n]);
        end
    end

    assign cfg.cfg_ready_o = ready;

    // Per-channel counter, output register, pending-update capture and apply
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NCH; n++) begin
                div_q[n]  <= DIV_RST_N;
                cnt_q[n]  <= '0;
                pdiv_q[n] <= DIV_RST_N;
            end
            en_q   <= EN_RST;
            pen_q  <= '0;
            pend_q <= '0;
            clk_q  <= '0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (accept[n]) begin
                    pen_q[n]  <= cfg.cfg_en_i;
                    pdiv_q[n] <= norm_div(cfg.cfg_div_i);
                    pend_q[n] <= 1'b1;
                end else if (apply[n]) begin
                    pend_q[n] <= 1'b0;
                end

                if (apply[n]) begin
                    div_q[n] <= pdiv_q[n];
                    en_q[n]  <= pen_q[n];
                    cnt_q[n] <= '0;
                end else if (en_q[n]) begin
                    cnt_q[n] <= wrap[n] ? '0 : cnt_q[n] + DW'(1);
                end else begin
                    cnt_q[n] <= '0;
                end

                clk_q[n] <= en_q[n] & (cnt_q[n] < (div_q[n] >> 1));
            end
        end
    end

    assign clk_o  = clk_q;
    assign busy_o = pend_q;

endmodule

// File: tb/tb_scu_clk_div6.sv
// Directed self-checking bench for scu_clk_div6 (DIV_RST=2, all channels enabled).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_scu_clk_div6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] clk_o;
    logic [5:0] busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    scu_clk_div6_if cfg ();

    scu_clk_div6 #(
        .DIV_RST(2),
        .EN_RST (6'b111111)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cfg   (cfg),
        .clk_o (clk_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cfg.cfg_valid_i = 1'b0;
        cfg.cfg_sel_i   = 3'd0;
        cfg.cfg_en_i    = 1'b0;
        cfg.cfg_div_i   = 8'd0;
    endtask

    task automatic drive(input logic [2:0] s, input logic e, input logic [7:0] d);
        cfg.cfg_valid_i = 1'b1;
        cfg.cfg_sel_i   = s;
        cfg.cfg_en_i    = e;
        cfg.cfg_div_i   = d;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Reset values, then all channels toggle 1,0,1,0 from the first edge
    task automatic test_reset();
        logic [5:0] ec [4];
        ec = '{6'h3F, 6'h00, 6'h3F, 6'h00};
        idle();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (clk_o !== 6'h00) begin n_fail++; $display("FAIL rst_clk: got %h expected 00", clk_o); end
        n_checks++;
        if (busy_o !== 6'h00) begin n_fail++; $display("FAIL rst_busy: got %h expected 00", busy_o); end
        n_checks++;
        if (cfg.cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", cfg.cfg_ready_o); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (clk_o !== ec[i]) begin n_fail++; $display("FAIL reset_toggle[%0d]: got %h expected %h", i, clk_o, ec[i]); end
            n_checks++;
            if (busy_o !== 6'h00) begin n_fail++; $display("FAIL reset_busy[%0d]: got %h expected 00", i, busy_o); end
        end
    endtask

    // ch3 to div 6 while others run at 2
    task automatic test_div6();
        logic [5:0] ec [9];
        logic [5:0] eb [9];
        logic       er [9];
        ec = '{6'h3F, 6'h00, 6'h3F, 6'h08, 6'h3F, 6'h00, 6'h37, 6'h00, 6'h3F};
        eb = '{6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        er = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        drive(3'd3, 1'b1, 8'd6);
        n_checks++;
        if (cfg.cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL div6_ready_pre: got %b expected 1", cfg.cfg_ready_o); end
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 0) cfg.cfg_valid_i = 1'b0;
            n_checks++;
            if (clk_o !== ec[i]) begin n_fail++; $display("FAIL div6_clk[%0d]: got %h expected %h", i, clk_o, ec[i]); end
            n_checks++;
            if (busy_o !== eb[i]) begin n_fail++; $display("FAIL div6_busy[%0d]: got %h expected %h", i, busy_o, eb[i]); end
            n_checks++;
            if (cfg.cfg_ready_o !== er[i]) begin n_fail++; $display("FAIL div6_ready[%0d]: got %b expected %b", i, cfg.cfg_ready_o, er[i]); end
        end
        idle();
    endtask

    // ch1 to div 5: 2 high / 3 low with odd ratios, otherwise div 4
    task automatic test_odd();
        logic [5:0] ec [8];
`ifdef SCU_CLK_DIV_ODD_EN
        ec = '{6'h3F, 6'h00, 6'h3F, 6'h02, 6'h3D, 6'h00, 6'h3D, 6'h02};
`else
        ec = '{6'h3F, 6'h00, 6'h3F, 6'h02, 6'h3D, 6'h00, 6'h3F, 6'h02};
`endif
        do_reset();
        drive(3'd1, 1'b1, 8'd5);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) cfg.cfg_valid_i = 1'b0;
            n_checks++;
            if (clk_o !== ec[i]) begin n_fail++; $display("FAIL odd_clk[%0d]: got %h expected %h", i, clk_o, ec[i]); end
        end
        idle();
    endtask

    // ch5 at div 8, disabled mid-high (period completes), re-enabled at div 4
    task automatic test_disable();
        logic e5 [19];
        logic b5 [19];
        e5 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        b5 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        drive(3'd5, 1'b1, 8'd8);
        for (int i = 0; i < 19; i++) begin
            step();
            if (i == 0 || i == 4 || i == 12) cfg.cfg_valid_i = 1'b0;
            if (i == 3)  drive(3'd5, 1'b0, 8'd8);
            if (i == 11) drive(3'd5, 1'b1, 8'd4);
            n_checks++;
            if (clk_o[5] !== e5[i]) begin n_fail++; $display("FAIL dis_clk5[%0d]: got %b expected %b", i, clk_o[5], e5[i]); end
            n_checks++;
            if (busy_o[5] !== b5[i]) begin n_fail++; $display("FAIL dis_busy5[%0d]: got %b expected %b", i, busy_o[5], b5[i]); end
            n_checks++;
            if (clk_o[4:0] !== ((i % 2 == 0) ? 5'h1F : 5'h00)) begin
                n_fail++; $display("FAIL dis_others[%0d]: got %h", i, clk_o[4:0]);
            end
        end
        idle();
    endtask

    // ch2 div 0 clamps to 2; a second write while busy stalls until apply
    task automatic test_clamp();
        logic [5:0] ec [11];
        logic [5:0] eb [11];
        logic       er [11];
        ec = '{6'h3F, 6'h00, 6'h3F, 6'h00, 6'h3F, 6'h04, 6'h3F, 6'h00, 6'h3B, 6'h00, 6'h3F};
        eb = '{6'h04, 6'h00, 6'h04, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        er = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        drive(3'd2, 1'b1, 8'd0);
        for (int i = 0; i < 11; i++) begin
            step();
            if (i == 0) drive(3'd2, 1'b1, 8'd6);
            if (i == 2) cfg.cfg_valid_i = 1'b0;
            n_checks++;
            if (clk_o !== ec[i]) begin n_fail++; $display("FAIL clamp_clk[%0d]: got %h expected %h", i, clk_o, ec[i]); end
            n_checks++;
            if (busy_o !== eb[i]) begin n_fail++; $display("FAIL clamp_busy[%0d]: got %h expected %h", i, busy_o, eb[i]); end
            n_checks++;
            if (cfg.cfg_ready_o !== er[i]) begin n_fail++; $display("FAIL clamp_ready[%0d]: got %b expected %b", i, cfg.cfg_ready_o, er[i]); end
        end
        idle();
    endtask

    // sel 6/7 are always ready and change nothing
    task automatic test_sel_ignored();
        logic [5:0] ec [4];
        ec = '{6'h3F, 6'h00, 6'h3F, 6'h00};
        do_reset();
        drive(3'd6, 1'b0, 8'd50);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cfg.cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL sel_ready[%0d]: got %b expected 1", i, cfg.cfg_ready_o); end
            step();
            if (i == 0) cfg.cfg_sel_i = 3'd7;
            if (i == 1) cfg.cfg_valid_i = 1'b0;
            n_checks++;
            if (clk_o !== ec[i]) begin n_fail++; $display("FAIL sel_clk[%0d]: got %h expected %h", i, clk_o, ec[i]); end
            n_checks++;
            if (busy_o !== 6'h00) begin n_fail++; $display("FAIL sel_busy[%0d]: got %h expected 00", i, busy_o); end
        end
        idle();
    endtask

    // reset while ch4 holds a pending update, then ch4 runs at DIV_RST
    task automatic test_rst_midop();
        logic [5:0] ec [4];
        ec = '{6'h3F, 6'h00, 6'h3F, 6'h00};
        do_reset();
        drive(3'd4, 1'b1, 8'd200);
        step();
        cfg.cfg_valid_i = 1'b0;
        step();
        drive(3'd4, 1'b1, 8'd200);
        n_checks++;
        if (cfg.cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_ready_pre: got %b expected 1", cfg.cfg_ready_o); end
        step();
        cfg.cfg_valid_i = 1'b0;
        n_checks++;
        if (busy_o !== 6'h10) begin n_fail++; $display("FAIL mid_busy_set: got %h expected 10", busy_o); end
        step();
        step();
        n_checks++;
        if (clk_o !== 6'h3F) begin n_fail++; $display("FAIL mid_clk_pre: got %h expected 3f", clk_o); end
        n_checks++;
        if (busy_o !== 6'h10) begin n_fail++; $display("FAIL mid_busy_hold: got %h expected 10", busy_o); end
        rst = 1'b1;
        step();
        n_checks++;
        if (clk_o !== 6'h00) begin n_fail++; $display("FAIL mid_rst_clk: got %h expected 00", clk_o); end
        n_checks++;
        if (busy_o !== 6'h00) begin n_fail++; $display("FAIL mid_rst_busy: got %h expected 00", busy_o); end
        n_checks++;
        if (cfg.cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 1", cfg.cfg_ready_o); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (clk_o !== ec[i]) begin n_fail++; $display("FAIL mid_after[%0d]: got %h expected %h", i, clk_o, ec[i]); end
            n_checks++;
            if (busy_o !== 6'h00) begin n_fail++; $display("FAIL mid_after_busy[%0d]: got %h expected 00", i, busy_o); end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_div6();
        test_odd();
        test_disable();
        test_clamp();
        test_sel_ignored();
        test_rst_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
